// File: rtl/pri_range_gate_capture.sv
// Range-gate capture: per PRI, skip a programmable number of ADC samples, then frame
// a fixed-length range line tagged with PRI index, first-PRI flag, bank and waveform.
module pri_range_gate_capture #(
  parameter int DW    = 16,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_pri_p,
  input  logic             i_cpi_p,
  input  logic             i_mem_sel,
  input  logic [2:0]       i_waveform_type,
  input  logic [15:0]      i_valid_start_idx,
  input  logic [15:0]      i_nsample_pri,
  input  logic [DW-1:0]    i_adc_data,
  input  logic             i_adc_valid,
  output logic [DW-1:0]    o_data,
  output logic             o_valid,
  output logic             o_sop,
  output logic             o_eop,
  output logic [IDX_W-1:0] o_pri_idx,
  output logic             o_first_pri,
  output logic             o_mem_sel,
  output logic [2:0]       o_wave_type,
  output logic             o_busy,
  output logic             o_abort
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SKIP = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [15:0] start_idx;
  logic [15:0] nsample;
  logic        cpi_pending;
  logic        skip_done;
  logic        last_capt;

  assign skip_done = (cnt == start_idx - 16'd1);
  assign last_capt = (cnt == nsample - 16'd1);
  assign o_busy    = (state != ST_IDLE);

  // Control: state, sample counter, CPI bookkeeping and per-line tags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      start_idx   <= '0;
      nsample     <= '0;
      cpi_pending <= 1'b1;
      o_pri_idx   <= '0;
      o_first_pri <= 1'b0;
      o_mem_sel   <= 1'b0;
      o_wave_type <= '0;
      o_abort     <= 1'b0;
    end else begin
      o_abort <= 1'b0;
      if (i_pri_p) begin
        // A new PRI always wins; an unfinished line is cut and flagged.
        o_abort     <= (state != ST_IDLE);
        start_idx   <= i_valid_start_idx;
        nsample     <= i_nsample_pri;
        o_mem_sel   <= i_mem_sel;
        o_wave_type <= i_waveform_type;
        cnt         <= '0;
        if (cpi_pending || i_cpi_p) begin
          o_pri_idx   <= '0;
          o_first_pri <= 1'b1;
          cpi_pending <= 1'b0;
        end else begin
          o_pri_idx   <= o_pri_idx + IDX_W'(1);
          o_first_pri <= 1'b0;
        end
        if (i_valid_start_idx != 16'd0)
          state <= ST_SKIP;
        else if (i_nsample_pri != 16'd0)
          state <= ST_CAPT;
        else
          state <= ST_IDLE;
      end else begin
        if (i_cpi_p)
          cpi_pending <= 1'b1;
        case (state)
          ST_SKIP: begin
            if (i_adc_valid) begin
              if (skip_done) begin
                state <= ST_CAPT;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          ST_CAPT: begin
            if (i_adc_valid) begin
              if (last_capt)
                state <= ST_IDLE;
              else
                cnt <= cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output beat: one registered sample per captured ADC strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      if (!i_pri_p && state == ST_CAPT && i_adc_valid) begin
        o_data  <= i_adc_data;
        o_valid <= 1'b1;
        o_sop   <= (cnt == 16'd0);
        o_eop   <= last_capt;
      end
    end
  end

endmodule

// File: tb/tb_pri_range_gate_capture.sv
// Bench for pri_range_gate_capture: directed scenarios plus random traffic, checked
// cycle by cycle against a sample-numbering reference model.
module tb_pri_range_gate_capture;
  localparam int DW    = 16;
  localparam int IDX_W = 16;
  localparam int VW    = DW + 3 + IDX_W + 1 + 1 + 3 + 1 + 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             pri, cpi, mem, adc_valid;
  logic [2:0]       wave;
  logic [15:0]      vs, ns;
  logic [DW-1:0]    adc;
  logic [DW-1:0]    o_data;
  logic             o_valid, o_sop, o_eop, o_first_pri, o_mem_sel, o_busy, o_abort;
  logic [IDX_W-1:0] o_pri_idx;
  logic [2:0]       o_wave_type;

  int n_checks = 0;
  int n_fail   = 0;

  pri_range_gate_capture #(.DW(DW), .IDX_W(IDX_W)) dut (
    .clk(clk), .rstn(rstn), .i_pri_p(pri), .i_cpi_p(cpi), .i_mem_sel(mem),
    .i_waveform_type(wave), .i_valid_start_idx(vs), .i_nsample_pri(ns),
    .i_adc_data(adc), .i_adc_valid(adc_valid),
    .o_data(o_data), .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop),
    .o_pri_idx(o_pri_idx), .o_first_pri(o_first_pri), .o_mem_sel(o_mem_sel),
    .o_wave_type(o_wave_type), .o_busy(o_busy), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  // Reference model: a line is "the k-th valid sample after the PRI pulse";
  // samples k = start+1 .. start+nsample are emitted as captures 0 .. nsample-1.
  logic [DW-1:0]    e_data;
  logic             e_valid, e_sop, e_eop, e_first, e_mem, e_busy, e_abort;
  logic [IDX_W-1:0] e_idx;
  logic [2:0]       e_wave;
  bit               m_pending;
  int               m_seen, m_start, m_n;

  task automatic model_reset();
    e_data = '0; e_valid = 0; e_sop = 0; e_eop = 0; e_first = 0; e_mem = 0;
    e_busy = 0; e_abort = 0; e_idx = '0; e_wave = '0;
    m_pending = 1; m_seen = 0; m_start = 0; m_n = 0;
  endtask

  task automatic model_step();
    int c;
    if (!rstn) begin
      model_reset();
      return;
    end
    e_valid = 0; e_sop = 0; e_eop = 0; e_abort = 0;
    if (pri) begin
      e_abort = e_busy;
      if (m_pending || cpi) begin
        e_idx = '0; e_first = 1; m_pending = 0;
      end else begin
        e_idx = e_idx + IDX_W'(1); e_first = 0;
      end
      e_mem = mem; e_wave = wave;
      m_start = int'(vs); m_n = int'(ns); m_seen = 0;
      e_busy = (m_start + m_n) > 0;
    end else begin
      if (cpi) m_pending = 1;
      if (e_busy && adc_valid) begin
        m_seen++;
        if (m_seen > m_start) begin
          c = m_seen - m_start - 1;
          e_valid = 1; e_data = adc;
          e_sop = (c == 0); e_eop = (c == m_n - 1);
          if (e_eop) e_busy = 0;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {o_data, o_valid, o_sop, o_eop, o_pri_idx, o_first_pri, o_mem_sel,
            o_wave_type, o_busy, o_abort};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_data, e_valid, e_sop, e_eop, e_idx, e_first, e_mem, e_wave, e_busy, e_abort};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pri = 0; cpi = 0; mem = 0; wave = '0; vs = '0; ns = '0; adc = '0; adc_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    model_reset();
    #2;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h need 0", dut_vec());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_hold cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
    end
    rstn = 1;
  endtask

  task automatic test_basic();
    int nv = 0;
    logic [DW-1:0] sop_d = '1, eop_d = '1;
    cpi = 1; pri = 1; vs = 16'd3; ns = 16'd19; mem = 1; wave = 3'd5;
    adc_valid = 1; adc = '0;
    for (int i = 0; i < 35; i++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL basic cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
      if (o_valid) nv++;
      if (o_sop) sop_d = o_data;
      if (o_eop) eop_d = o_data;
      cpi = 0; pri = 0; adc = adc + DW'(1);
    end
    n_checks++;
    if (nv != 19) begin n_fail++; $display("FAIL basic_count: got %0d need 19", nv); end
    n_checks++;
    if (sop_d !== 16'd4) begin n_fail++; $display("FAIL basic_sop_data: got %0d need 4", sop_d); end
    n_checks++;
    if (eop_d !== 16'd22) begin n_fail++; $display("FAIL basic_eop_data: got %0d need 22", eop_d); end
    n_checks++;
    if (o_pri_idx !== '0 || o_first_pri !== 1'b1) begin
      n_fail++; $display("FAIL basic_tag: idx %0d first %b need 0/1", o_pri_idx, o_first_pri);
    end
  endtask

  task automatic test_pri_sequence();
    logic          m_drv;
    logic [2:0]    w_drv;
    logic [IDX_W-1:0] sop_idx;
    logic          sop_first, sop_mem;
    logic [2:0]    sop_wave;
    for (int k = 1; k <= 4; k++) begin
      m_drv = 1'($urandom); w_drv = 3'($urandom);
      pri = 1; vs = 16'd3; ns = 16'd19; mem = m_drv; wave = w_drv; adc_valid = 1;
      sop_idx = '1; sop_first = 1; sop_mem = ~m_drv; sop_wave = ~w_drv;
      for (int i = 0; i < 130; i++) begin
        adc = DW'($urandom);
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL seq pri %0d cyc %0d: got %h need %h", k, i, dut_vec(), exp_vec());
        end
        if (o_sop) begin
          sop_idx = o_pri_idx; sop_first = o_first_pri; sop_mem = o_mem_sel; sop_wave = o_wave_type;
        end
        pri = 0; mem = ~m_drv; wave = ~w_drv;
      end
      n_checks++;
      if (sop_idx !== IDX_W'(k) || sop_first !== 1'b0 || sop_mem !== m_drv || sop_wave !== w_drv) begin
        n_fail++;
        $display("FAIL seq_tag pri %0d: idx %0d first %b mem %b wave %0d need %0d/0/%b/%0d",
                 k, sop_idx, sop_first, sop_mem, sop_wave, k, m_drv, w_drv);
      end
    end
  endtask

  task automatic test_sparse();
    int nv = 0, nsop = 0, neop = 0;
    pri = 1; vs = 16'd0; ns = 16'd4;
    for (int i = 0; i < 16; i++) begin
      adc_valid = (i % 2 == 1); adc = DW'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL sparse cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
      if (o_valid) nv++;
      if (o_sop) nsop++;
      if (o_eop) neop++;
      pri = 0;
    end
    n_checks++;
    if (nv != 4 || nsop != 1 || neop != 1) begin
      n_fail++; $display("FAIL sparse_frame: valid %0d sop %0d eop %0d need 4/1/1", nv, nsop, neop);
    end
  endtask

  task automatic test_abort();
    int nv = 0, nsop = 0, neop = 0, nab = 0;
    logic [IDX_W-1:0] idx1 = '0, idx2 = '0;
    adc_valid = 1; vs = 16'd0; ns = 16'd19;
    for (int i = 0; i < 40; i++) begin
      pri = (i == 0 || i == 10);
      adc = DW'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
      if (o_valid) nv++;
      if (o_eop) neop++;
      if (o_abort) nab++;
      if (o_sop) begin
        nsop++;
        if (nsop == 1) idx1 = o_pri_idx; else idx2 = o_pri_idx;
      end
    end
    pri = 0;
    n_checks++;
    if (nab != 1 || nv != 28 || nsop != 2 || neop != 1) begin
      n_fail++; $display("FAIL abort_frame: abort %0d valid %0d sop %0d eop %0d need 1/28/2/1",
                         nab, nv, nsop, neop);
    end
    n_checks++;
    if (idx2 !== idx1 + IDX_W'(1)) begin
      n_fail++; $display("FAIL abort_idx: got %0d need %0d", idx2, idx1 + IDX_W'(1));
    end
  endtask

  task automatic test_zero_one();
    logic [IDX_W-1:0] idx0;
    int nv = 0;
    logic beat_sop = 0, beat_eop = 0;
    idx0 = o_pri_idx;
    adc_valid = 1; vs = 16'd0;
    for (int i = 0; i < 12; i++) begin
      pri = (i == 0 || i == 5);
      ns  = (i == 5) ? 16'd1 : 16'd0;
      adc = DW'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL zero_one cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
      if (o_valid) begin nv++; beat_sop = o_sop; beat_eop = o_eop; end
    end
    pri = 0;
    n_checks++;
    if (nv != 1 || !beat_sop || !beat_eop) begin
      n_fail++; $display("FAIL zero_one_beat: valid %0d sop %b eop %b need 1/1/1", nv, beat_sop, beat_eop);
    end
    n_checks++;
    if (o_pri_idx !== idx0 + IDX_W'(2)) begin
      n_fail++; $display("FAIL zero_one_idx: got %0d need %0d", o_pri_idx, idx0 + IDX_W'(2));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      pri = ($urandom_range(24) == 0);
      cpi = ($urandom_range(59) == 0);
      mem = 1'($urandom); wave = 3'($urandom);
      if ($urandom_range(7) == 0) begin
        vs = 16'd0; ns = 16'd0;
      end else begin
        vs = 16'($urandom_range(8)); ns = 16'($urandom_range(24, 1));
      end
      adc_valid = ($urandom_range(3) != 0);
      adc = DW'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    cpi = 1; pri = 1; vs = 16'd2; ns = 16'd19; adc_valid = 1;
    for (int i = 0; i < 8; i++) begin
      adc = DW'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rst_mid pre cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
      cpi = 0; pri = 0;
    end
    #3 rstn = 0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL rst_mid_async: got %h need 0", dut_vec());
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rst_mid hold cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
    end
    rstn = 1;
    cpi = 1; pri = 1; vs = 16'd1; ns = 16'd5;
    for (int i = 0; i < 12; i++) begin
      adc = DW'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rst_mid post cyc %0d: got %h need %h", i, dut_vec(), exp_vec());
      end
      cpi = 0; pri = 0;
    end
    n_checks++;
    if (o_pri_idx !== '0 || o_first_pri !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_idx: idx %0d first %b need 0/1", o_pri_idx, o_first_pri);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pri_sequence();
    test_sparse();
    test_abort();
    test_zero_one();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
